// File: rtl/data_mem_responder.sv
// Data memory responder for the pipeline MEM stage.
//
// The responder accepts one request at a time over a valid/ready handshake. It
// stalls for WAIT cycles, performs the access and holds the response until the
// requester consumes it. The memory has DEPTH 32-bit words and is indexed by
// the word address addr[31:2]. Misaligned and out-of-range accesses do not
// touch memory; they return rsp_err = 1 with rsp_rdata = 0.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset (memory contents kept)
//   req_valid  in   request present
//   req_ready  out  responder can accept (IDLE only, not during reset)
//   req_we     in   1 = store, 0 = load
//   req_addr   in   byte address
//   req_wdata  in   store data
//   rsp_valid  out  response available (RESP state)
//   rsp_ready  in   requester consumes the response
//   rsp_rdata  out  load data (0 for stores and errors)
//   rsp_err    out  misaligned or out-of-range access
//   busy       out  state is not IDLE
module data_mem_responder #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WAIT  = 2    // legal range 0..15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] WAITST = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    localparam int unsigned IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DepthW   = 32'(DEPTH);
    localparam logic [3:0]  WaitInit = 4'(WAIT);
    localparam logic        WaitZero = (WAIT == 0);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        init_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    // Not reset: contents survive rst_n.
    logic [31:0] mem_q [DEPTH];

    logic        accept;
    logic        enter_resp;
    logic        acc_we;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [31:0] acc_word;
    logic [IdxW-1:0] acc_idx;
    logic        acc_err;

    // init_q keeps req_ready low until the first edge after reset release.
    assign req_ready = init_q & (state_q == IDLE);
    assign accept    = req_valid & req_ready;
    assign busy      = (state_q != IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    // With WAIT = 0 the access happens on the accept edge itself, so the
    // request inputs are used directly; otherwise the latched copy is used.
    assign enter_resp = (state_q == IDLE && accept && WaitZero) ||
                        (state_q == WAITST && cnt_q <= 4'd1);

    always_comb begin
        if (state_q == IDLE) begin
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
        end else begin
            acc_we    = we_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
        end
    end

    // No wrap-around: any word index at or beyond DEPTH is an error.
    assign acc_word = {2'b00, acc_addr[31:2]};
    assign acc_idx  = acc_addr[IdxW+1:2];
    assign acc_err  = (acc_addr[1:0] != 2'b00) | (acc_word >= DepthW);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d   = WaitInit;
                    state_d = WaitZero ? RESP : WAITST;
                end
            end
            WAITST: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                // Response fields clear on the handshake so rsp_err is 0
                // whenever rsp_valid is 0.
                if (rsp_ready) begin
                    state_d = IDLE;
                    rdata_d = 32'h0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        if (enter_resp) begin
            err_d   = acc_err;
            rdata_d = (!acc_we && !acc_err) ? mem_q[acc_idx] : 32'h0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            init_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            init_q  <= 1'b1;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end

    // enter_resp depends on state_q, which reset forces to IDLE, so an access
    // aborted by reset never reaches this write.
    always_ff @(posedge clk) begin
        if (enter_resp && acc_we && !acc_err) begin
            mem_q[acc_idx] <= acc_wdata;
        end
    end

endmodule
